// File: rtl/paillier_enc_sequencer.sv
// Paillier encryption sequencer: drives one shared modexp/modmul engine.
// Optional input range check enabled by defining PAILLIER_INPUT_CHECK_EN.
module paillier_enc_sequencer #(
    parameter int   RSA_WIDTH = 4096,
    parameter logic OP_MODEXP = 1'b0,
    parameter logic OP_MODMUL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [RSA_WIDTH-1:0] m,
    input  logic [RSA_WIDTH-1:0] r,
    input  logic [RSA_WIDTH-1:0] n,
    input  logic [RSA_WIDTH-1:0] exp_n,
    input  logic [RSA_WIDTH-1:0] g,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [RSA_WIDTH-1:0] result,
    output logic                 eng_go,
    output logic                 eng_op,
    output logic [RSA_WIDTH-1:0] eng_a,
    output logic [RSA_WIDTH-1:0] eng_b,
    output logic [RSA_WIDTH-1:0] eng_mod,
    input  logic                 eng_done,
    input  logic [RSA_WIDTH-1:0] eng_result
);

    typedef enum logic [3:0] {
        IDLE, CHECK, EXP_G, WAIT_G, EXP_R, WAIT_R, MUL, WAIT_M, DONE
    } state_t;

    state_t               state;
    logic [RSA_WIDTH-1:0] m_q;
    logic [RSA_WIDTH-1:0] r_q;
    logic [RSA_WIDTH-1:0] n_q;
    logic [RSA_WIDTH-1:0] g_q;
    logic [RSA_WIDTH-1:0] gm;

    // Engine commands are registered on entry to EXP_G/EXP_R/MUL so the
    // operand bus is already stable in the cycle eng_go is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            result  <= '0;
            eng_go  <= 1'b0;
            eng_op  <= 1'b0;
            eng_a   <= '0;
            eng_b   <= '0;
            eng_mod <= '0;
            m_q     <= '0;
            r_q     <= '0;
            n_q     <= '0;
            g_q     <= '0;
            gm      <= '0;
        end else begin
            eng_go <= 1'b0;
            done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        m_q     <= m;
                        r_q     <= r;
                        n_q     <= n;
                        g_q     <= g;
                        eng_mod <= exp_n;
                        busy    <= 1'b1;
                        err     <= 1'b0;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
`ifdef PAILLIER_INPUT_CHECK_EN
                    if (m_q >= n_q || r_q == '0 || r_q >= n_q) begin
                        err    <= 1'b1;
                        result <= '0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end else begin
                        eng_go <= 1'b1;
                        eng_op <= OP_MODEXP;
                        eng_a  <= g_q;
                        eng_b  <= m_q;
                        state  <= EXP_G;
                    end
`else
                    eng_go <= 1'b1;
                    eng_op <= OP_MODEXP;
                    eng_a  <= g_q;
                    eng_b  <= m_q;
                    state  <= EXP_G;
`endif
                end
                EXP_G: state <= WAIT_G;
                WAIT_G: begin
                    if (eng_done) begin
                        gm     <= eng_result;
                        eng_go <= 1'b1;
                        eng_op <= OP_MODEXP;
                        eng_a  <= r_q;
                        eng_b  <= n_q;
                        state  <= EXP_R;
                    end
                end
                EXP_R: state <= WAIT_R;
                WAIT_R: begin
                    if (eng_done) begin
                        eng_go <= 1'b1;
                        eng_op <= OP_MODMUL;
                        eng_a  <= gm;
                        eng_b  <= eng_result;
                        state  <= MUL;
                    end
                end
                MUL: state <= WAIT_M;
                WAIT_M: begin
                    if (eng_done) begin
                        result <= eng_result;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_paillier_enc_sequencer.sv
// Directed bench for paillier_enc_sequencer with a behavioural engine.
module tb_paillier_enc_sequencer;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] m = '0, r = '0, n = 16'd15, exp_n = 16'd225, g = 16'd16;
    logic         busy, done, err, eng_go, eng_op;
    logic [W-1:0] result, eng_a, eng_b, eng_mod;
    logic         eng_done;
    logic [W-1:0] eng_result;

    int total = 0;
    int bad = 0;
    int gos = 0;
    int unstable = 0;
    int fix_lat = 5;
    bit rand_lat = 1'b0;
    int cnt = 0;
    logic         l_op;
    logic [W-1:0] l_a, l_b, l_mod;
    logic [W-1:0] log_op[$];
    logic [W-1:0] log_a[$];
    logic [W-1:0] log_b[$];
    logic [W-1:0] log_mod[$];

    always #5 clk = ~clk;

    paillier_enc_sequencer #(.RSA_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .m(m), .r(r), .n(n), .exp_n(exp_n), .g(g),
        .busy(busy), .done(done), .err(err), .result(result),
        .eng_go(eng_go), .eng_op(eng_op), .eng_a(eng_a),
        .eng_b(eng_b), .eng_mod(eng_mod),
        .eng_done(eng_done), .eng_result(eng_result)
    );

    function automatic logic [W-1:0] expmod(input longint a, input longint b,
                                            input longint md);
        longint res = 1;
        longint base = a % md;
        longint e = b;
        while (e > 0) begin
            if (e[0]) res = (res * base) % md;
            base = (base * base) % md;
            e = e >> 1;
        end
        return W'(res);
    endfunction

    // Engine model: eng_done arrives L cycles after the eng_go cycle
    always @(posedge clk or negedge rst_n) begin
        int lat;
        if (!rst_n) begin
            cnt      <= 0;
            eng_done <= 1'b0;
        end else begin
            eng_done <= 1'b0;
            if (eng_go) begin
                lat = rand_lat ? int'($urandom_range(1, 20)) : fix_lat;
                l_op  <= eng_op;
                l_a   <= eng_a;
                l_b   <= eng_b;
                l_mod <= eng_mod;
                eng_result <= eng_op ? W'((longint'(eng_a) * longint'(eng_b))
                                          % longint'(eng_mod))
                                     : expmod(eng_a, eng_b, eng_mod);
                log_op.push_back(W'(eng_op));
                log_a.push_back(eng_a);
                log_b.push_back(eng_b);
                log_mod.push_back(eng_mod);
                gos <= gos + 1;
                if (lat == 1) eng_done <= 1'b1;
                else cnt <= lat - 1;
            end else if (cnt != 0) begin
                if (eng_op !== l_op || eng_a !== l_a || eng_b !== l_b ||
                    eng_mod !== l_mod)
                    unstable <= unstable + 1;
                cnt <= cnt - 1;
                if (cnt == 1) eng_done <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_op.delete();
        log_a.delete();
        log_b.delete();
        log_mod.delete();
    endtask

    // Waits for done; lat counts cycles from the start cycle through done
    task automatic wait_done(inout int lat);
        while (!done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic run_op(input logic [W-1:0] mm, input logic [W-1:0] rr,
                          output int lat);
        @(negedge clk);
        m = mm;
        r = rr;
        start = 1'b1;
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        lat = 2;
        chk("busy_after_accept", busy, 1);
        wait_done(lat);
    endtask

    initial begin
        int lat;
        int g0;
        int k;

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_go", eng_go, 0);
        chk("rst_result", result, 0);
        chk("rst_eng_a", eng_a, 0);
        chk("rst_eng_mod", eng_mod, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic encryption
        clear_log();
        g0 = gos;
        run_op(16'd2, 16'd2, lat);
        chk("basic_result", result, 158);
        chk("basic_err", err, 0);
        chk("basic_latency", lat, 21);
        chk("basic_busy_at_done", busy, 0);
        chk("basic_gos", gos - g0, 3);
        if (log_op.size() == 3) begin
            chk("cmd0_op", log_op[0], 0);
            chk("cmd0_a", log_a[0], 16);
            chk("cmd0_b", log_b[0], 2);
            chk("cmd0_mod", log_mod[0], 225);
            chk("cmd1_op", log_op[1], 0);
            chk("cmd1_a", log_a[1], 2);
            chk("cmd1_b", log_b[1], 15);
            chk("cmd2_op", log_op[2], 1);
            chk("cmd2_a", log_a[2], 31);
            chk("cmd2_b", log_b[2], 143);
            chk("cmd2_mod", log_mod[2], 225);
        end else begin
            chk("cmd_log_size", log_op.size(), 3);
        end
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("result_held", result, 158);

        // trivial operands
        g0 = gos;
        run_op(16'd0, 16'd1, lat);
        chk("trivial_result", result, 1);
        chk("trivial_gos", gos - g0, 3);

        // busy rejection: second start during WAIT_R
        g0 = gos;
        @(negedge clk);
        m = 16'd2;
        r = 16'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 2;
        k = 0;
        while (gos - g0 < 2 && k < 200) begin
            @(negedge clk);
            k++;
            lat++;
        end
        chk("reach_wait_r", gos - g0, 2);
        @(negedge clk);
        lat++;
        m = 16'd7;
        start = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        chk("reject_busy", busy, 1);
        wait_done(lat);
        chk("reject_result", result, 158);
        chk("reject_gos", gos - g0, 3);
        @(negedge clk);
        chk("reject_no_restart", busy, 0);

        // start held through DONE restarts in the next IDLE cycle
        g0 = gos;
        @(negedge clk);
        m = 16'd2;
        start = 1'b1;
        lat = 1;
        wait_done(lat);
        @(negedge clk);
        chk("held_idle_busy", busy, 0);
        @(negedge clk);
        chk("held_restart_busy", busy, 1);
        start = 1'b0;
        lat = 2;
        wait_done(lat);
        chk("held_result", result, 158);
        chk("held_gos", gos - g0, 6);

        // reset mid-operation during WAIT_G
        g0 = gos;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (gos == g0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_go", eng_go, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'd2, 16'd2, lat);
        chk("post_rst_result", result, 158);

        // randomized engine latency
        rand_lat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_op(16'd2, 16'd2, lat);
            chk("randlat_result", result, 158);
        end
        chk("operand_stability", unstable, 0);
        rand_lat = 1'b0;

        // m out of range
        g0 = gos;
        run_op(16'd15, 16'd2, lat);
`ifdef PAILLIER_INPUT_CHECK_EN
        chk("chk_err", err, 1);
        chk("chk_result", result, 0);
        chk("chk_gos", gos - g0, 0);
        chk("chk_latency", lat, 3);
`else
        chk("nochk_err", err, 0);
        chk("nochk_gos", gos - g0, 3);
        chk("nochk_result", result, 143);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
